// File: rtl/count_checker_pkg.sv
// count_checker_pkg: shared state encoding and default parameters for the count checker.
package count_checker_pkg;
  typedef enum logic [1:0] {UNSYNC, SYNC, LOCKED} state_t;
  localparam int WIDTH_D       = 8;
  localparam int LOCK_RUN_D    = 4;
  localparam int LOSS_THRESH_D = 3;
  localparam int ERRW_D        = 8;
endpackage

// File: rtl/count_checker_if.sv
// count_checker_if: strobe/count input and status outputs of the count checker.
interface count_checker_if #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 8
);
  logic             sample_en;
  logic [WIDTH-1:0] cnt_in;
  logic             locked;
  logic             err_pulse;
  logic [ERRW-1:0]  err_count;
  logic [WIDTH-1:0] last_value;
  modport master (output sample_en, cnt_in, input locked, err_pulse, err_count, last_value);
  modport slave  (input sample_en, cnt_in, output locked, err_pulse, err_count, last_value);
endinterface

// File: rtl/count_checker_sat_cnt.sv
// count_checker_sat_cnt: up-counter with clear and increment enable that sticks at all-ones.
module count_checker_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/count_checker.sv
// count_checker: locks onto a +1 count sequence and flags bad steps while locked.
// COUNT_CHECKER_STALL_EN: a repeated value (hold step) is neutral in every state.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH       = WIDTH_D,
  parameter int LOCK_RUN    = LOCK_RUN_D,
  parameter int LOSS_THRESH = LOSS_THRESH_D,
  parameter int ERRW        = ERRW_D
) (
  input  logic            clk,
  input  logic            rst,
  count_checker_if.slave  bus
);
  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int MW = $clog2(LOSS_THRESH + 1);
  state_t           state, state_nx;
  logic [RW-1:0]    run, run_nx;
  logic [MW-1:0]    miss, miss_nx;
  logic [WIDTH-1:0] last;
  logic             good, neutral, err_nx, err_q;
  logic [ERRW-1:0]  err_count;
  assign good = bus.cnt_in == WIDTH'(last + 1'b1);
`ifdef COUNT_CHECKER_STALL_EN
  assign neutral = bus.cnt_in == last;
`else
  assign neutral = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= UNSYNC;
      run   <= '0;
      miss  <= '0;
      last  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= run_nx;
      miss  <= miss_nx;
      err_q <= err_nx;
      if (bus.sample_en) last <= bus.cnt_in;
    end
  always_comb begin
    state_nx = state;
    run_nx   = run;
    miss_nx  = miss;
    err_nx   = 1'b0;
    if (bus.sample_en && !neutral)
      case (state)
        UNSYNC: begin
          state_nx = SYNC;
          run_nx   = '0;
        end
        SYNC: begin
          run_nx = good ? run + 1'b1 : '0;
          if (good && run == RW'(LOCK_RUN - 1)) begin
            state_nx = LOCKED;
            miss_nx  = '0;
          end
        end
        LOCKED: begin
          err_nx  = !good;
          miss_nx = good ? '0 : miss + 1'b1;
          // the step that exhausts the miss budget still pulses and counts
          if (!good && miss == MW'(LOSS_THRESH - 1)) begin
            state_nx = UNSYNC;
            miss_nx  = '0;
          end
        end
        default: state_nx = UNSYNC;
      endcase
  end
  count_checker_sat_cnt #(.W(ERRW)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (err_nx),
    .q   (err_count)
  );
  assign bus.locked     = state == LOCKED;
  assign bus.err_pulse  = err_q;
  assign bus.err_count  = err_count;
  assign bus.last_value = last;
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed stimulus against two checkers (ERRW=8 and ERRW=2) with a behavioural model.
module tb_count_checker;
  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [7:0] cnt_in;
  int total = 0;
  int bad   = 0;
  bit live  = 0;
  count_checker_if #(.WIDTH(8), .ERRW(8)) bus_a ();
  count_checker_if #(.WIDTH(8), .ERRW(2)) bus_b ();
  assign bus_a.sample_en = sample_en;
  assign bus_a.cnt_in    = cnt_in;
  assign bus_b.sample_en = sample_en;
  assign bus_b.cnt_in    = cnt_in;
  count_checker #(.ERRW(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  count_checker #(.ERRW(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  always #5 clk = ~clk;
  // model: phase 0 = waiting for first sample, 1 = counting run, 2 = locked
  int m_phase, m_run, m_miss, m_errs, m_ref;
  bit m_pulse;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask
  function automatic void model_reset();
    m_phase = 0; m_run = 0; m_miss = 0; m_errs = 0; m_ref = 0; m_pulse = 0;
  endfunction
  function automatic void model_sample(input bit en, input int v);
    bit good, neutral;
    m_pulse = 0;
    if (!en) return;
    good = v == ((m_ref + 1) % 256);
`ifdef COUNT_CHECKER_STALL_EN
    neutral = v == m_ref;
`else
    neutral = 0;
`endif
    if (!neutral) begin
      if (m_phase == 0) begin
        m_phase = 1; m_run = 0;
      end else if (m_phase == 1) begin
        m_run = good ? m_run + 1 : 0;
        if (m_run >= 4) begin m_phase = 2; m_miss = 0; end
      end else if (good) begin
        m_miss = 0;
      end else begin
        m_pulse = 1; m_errs++; m_miss++;
        if (m_miss >= 3) begin m_phase = 0; m_miss = 0; end
      end
    end
    m_ref = v;
  endfunction
  always @(negedge clk) if (live) begin
    chk("locked_a",    bus_a.locked,     m_phase == 2);
    chk("locked_b",    bus_b.locked,     m_phase == 2);
    chk("pulse_a",     bus_a.err_pulse,  m_pulse);
    chk("pulse_b",     bus_b.err_pulse,  m_pulse);
    chk("errcnt_a",    bus_a.err_count,  m_errs > 255 ? 255 : m_errs);
    chk("errcnt_b",    bus_b.err_count,  m_errs > 3 ? 3 : m_errs);
    chk("lastval_a",   bus_a.last_value, m_ref);
    chk("lastval_b",   bus_b.last_value, m_ref);
  end
  task automatic step(input bit en, input int v);
    sample_en = en;
    cnt_in    = 8'(v);
    @(posedge clk);
    model_sample(en, v);
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b0; sample_en = 1'b0; cnt_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    live = 1;
    chk("rst_locked", bus_a.locked, 0);
    chk("rst_errcnt", bus_a.err_count, 0);
    chk("rst_last",   bus_a.last_value, 0);
    rst = 1'b1;
    step(1, 'h05); step(1, 'h06); step(1, 'h07); step(1, 'h08);
    chk("prelock_08", bus_a.locked, 0);
    step(1, 'h09);
    chk("lock_09", bus_a.locked, 1);
    chk("lock_err0", bus_a.err_count, 0);
    for (int i = 'h0A; i <= 'hFF; i++) step(1, i);
    step(1, 'h00); step(1, 'h01);
    chk("wrap_locked", bus_a.locked, 1);
    chk("wrap_err0",   bus_a.err_count, 0);
    for (int i = 'h02; i <= 'h10; i++) step(1, i);
    step(1, 'h12);
    chk("skip_pulse", bus_a.err_pulse, 1);
    chk("skip_err1",  bus_a.err_count, 1);
    step(1, 'h13);
    chk("resume_pulse",  bus_a.err_pulse, 0);
    chk("resume_locked", bus_a.locked, 1);
    step(1, 'h40); step(1, 'h80);
    chk("miss2_locked", bus_a.locked, 1);
    step(1, 'h20);
    chk("loss_locked", bus_a.locked, 0);
    chk("loss_pulse",  bus_a.err_pulse, 1);
    chk("loss_err_a",  bus_a.err_count, 4);
    chk("loss_err_b",  bus_b.err_count, 3);
    step(1, 'h21);
    chk("recap_pulse", bus_a.err_pulse, 0);
    chk("recap_last",  bus_a.last_value, 'h21);
    repeat (3) step(0, 'hAA);
    chk("idle_last", bus_a.last_value, 'h21);
    step(1, 'h22); step(1, 'h23); step(1, 'h24);
    chk("relock_pre", bus_a.locked, 0);
    step(1, 'h25);
    chk("relock", bus_a.locked, 1);
    for (int i = 'h26; i <= 'h30; i++) step(1, i);
    step(1, 'h30);
`ifdef COUNT_CHECKER_STALL_EN
    chk("hold_pulse", bus_a.err_pulse, 0);
    chk("hold_err",   bus_a.err_count, 4);
`else
    chk("hold_pulse", bus_a.err_pulse, 1);
    chk("hold_err",   bus_a.err_count, 5);
`endif
    step(1, 'h31);
    step(1, 'h50); step(1, 'h51); step(1, 'h60); step(1, 'h61);
    chk("sat_b",       bus_b.err_count, 3);
    chk("sat_locked",  bus_a.locked, 1);
    step(1, 'h70);
    chk("pre_rst_pulse", bus_a.err_pulse, 1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_locked", bus_a.locked, 0);
    chk("arst_pulse",  bus_a.err_pulse, 0);
    chk("arst_err_a",  bus_a.err_count, 0);
    chk("arst_err_b",  bus_b.err_count, 0);
    chk("arst_last",   bus_a.last_value, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 'h70);
    chk("cap_locked", bus_a.locked, 0);
    chk("cap_last",   bus_a.last_value, 'h70);
    step(1, 'h71); step(1, 'h72); step(1, 'h73); step(1, 'h74);
    chk("final_lock", bus_a.locked, 1);
    live = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/count_checker.md
# count_checker

Sequence checker for the 8-bit free-running count driven onto the daughterboard LED bus. It samples the count at strobe points, locks once it sees a run of consecutive +1 steps, then flags each step that is not +1 modulo 2^WIDTH. It sits beside the counter as a self-test monitor, and its lock and error outputs can be routed to spare pins.

## Interface
- WIDTH, 8, width of the observed count
- LOCK_RUN, 4, consecutive correct steps needed to declare lock (≥1)
- LOSS_THRESH, 3, consecutive bad steps in LOCKED that drop lock (≥1)
- ERRW, 8, width of the saturating error counter
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- sample_en  input  1  strobe; cnt_in is valid and sampled this cycle
- cnt_in  input  WIDTH  observed count value
- locked  output  1  high while in LOCKED
- err_pulse  output  1  one-cycle pulse per bad step detected in LOCKED
- err_count  output  ERRW  saturating total of err_pulse events
- last_value  output  WIDTH  most recently sampled cnt_in

## Operation
- States: UNSYNC, SYNC, LOCKED.
- Every accepted sample (sample_en=1) loads last_value with cnt_in, in every state. Checks always compare against the previous last_value.
- "Good step": cnt_in == last_value + 1, truncated to WIDTH bits. 2^WIDTH-1 → 0 is good.
- UNSYNC: the first sample is captured. Go to SYNC, run=0.
- SYNC, good step: run+1. When run reaches LOCK_RUN, go to LOCKED, miss=0. If LOCK_RUN=1, a single good step locks.
- SYNC, bad step: run=0, stay in SYNC; the new value becomes the reference.
- LOCKED, good step: miss=0.
- LOCKED, bad step: err_pulse=1 and err_count+1 (saturates at 2^ERRW-1, never wraps), miss+1. When miss reaches LOSS_THRESH, go to UNSYNC. That final step still pulses and counts.
- err_pulse is never asserted outside LOCKED.
- sample_en=0: all state holds; err_pulse=0.
- run and miss counters are sized to hold LOCK_RUN and LOSS_THRESH respectively.

## Timing
- Reset (rst=0, asynchronous): state=UNSYNC, locked=0, err_pulse=0, err_count=0, last_value=0, run=0, miss=0.
- Reset asserted mid-operation clears everything immediately, including err_count. The first sample after release is treated as an UNSYNC capture.
- All outputs are registered. The effect of a sample at edge N is visible after edge N:
  - last_value updates at N.
  - err_pulse is high for cycle N..N+1 only.
  - locked rises or falls at N.
- Back-to-back strobes on every cycle are supported with no bubbles.
- No handshake back to the source; the checker never stalls the counter.

## Configuration
- COUNT_CHECKER_STALL_EN defined: a "hold step" (cnt_in == last_value) is neutral in every state.
  - run, miss, err_count and state are unchanged.
  - This lets the counter pause between strobes.
- Not defined: a hold step is a bad step like any other.

## Structure
- Package count_checker_pkg holds:
  - state enum (UNSYNC, SYNC, LOCKED)
  - default constants for WIDTH, LOCK_RUN, LOSS_THRESH, ERRW
- Sub-module count_checker_sat_cnt: generic saturating up-counter with clear and increment enable. It is used for err_count.
- FSM, step compare and run/miss counters live in count_checker.

## Test plan
- Reset, then strobes with 0x05,0x06,0x07,0x08,0x09 (LOCK_RUN=4) → locked rises after the 0x09 sample; err_count=0.
- Locked stream 0xFE,0xFF,0x00,0x01 → wrap accepted; locked stays 1; no err_pulse.
- Locked at 0x10, then 0x12 then 0x13 → one err_pulse on 0x12, err_count=1, locked stays 1; 0x13 is good.
- Locked, then three bad steps 0x40,0x80,0x20 → three pulses, err_count+3, locked falls after the third; the next sample recaptures into SYNC.
- Repeated 0x30,0x30 while locked → with COUNT_CHECKER_STALL_EN: no pulse. Without it: one err_pulse.
- ERRW=2 with five errors → err_count saturates at 3. rst pulsed low between clock edges → all outputs 0 immediately.
